// File: rtl/uart_xyz_tx.sv
// uart_xyz_tx
// UART 8N1 frame transmitter for x/y/z result vectors. On an accepted start
// pulse it latches three 32-bit words and sends a 14-byte frame on tx:
// HEADER, x/y/z bytes MSB-first (12 bytes), then an 8-bit additive checksum
// of the 12 payload bytes (header excluded, carry discarded).
//
// Parameters:
//   CLKS_PER_BIT - clk50 cycles per UART bit (>= 2)
//   HEADER       - first byte of every frame
// Ports:
//   clk50  in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   frame request, sampled only while idle
//   x,y,z  in   payload words, latched on accepted start
//   tx     out  registered serial line, idles high
//   busy   out  frame in progress
//   done   out  one-cycle pulse when the final stop bit ends
module uart_xyz_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] z,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA_BITS = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  localparam int unsigned    BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [95:0]   shadow;
  logic [7:0]    csum;
  logic [7:0]    cur_byte;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shadow   <= '0;
      csum     <= '0;
      cur_byte <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= START_BIT;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            csum     <= '0;
            shadow   <= {x, y, z};
            cur_byte <= HEADER;
          end
        end

        START_BIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA_BITS;
            // cur_byte is consumed LSB-first by shifting right each bit
            tx       <= cur_byte[0];
            cur_byte <= {1'b0, cur_byte[7:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA_BITS: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP_BIT;
              tx    <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              tx       <= cur_byte[0];
              cur_byte <= {1'b0, cur_byte[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP_BIT: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == 4'd13) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= START_BIT;
              tx       <= 1'b0;
              // Payload is taken from the top of the shadow register, which
              // shifts up a byte per load; the checksum is accumulated as each
              // payload byte is loaded, so it is complete when byte 13 loads.
              if (byte_idx == 4'd12) begin
                cur_byte <= csum;
              end else begin
                cur_byte <= shadow[95:88];
                shadow   <= {shadow[87:0], 8'h00};
                csum     <= csum + shadow[95:88];
              end
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xyz_tx.sv
// Directed self-checking bench for uart_xyz_tx: a fast instance
// (CLKS_PER_BIT=4) for frame content and control behaviour, and a
// default-parameter instance for bit timing.
module tb_uart_xyz_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst434 = 1'b0;
  logic        start = 1'b0;
  logic        start434 = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [31:0] z = '0;
  logic        tx4, busy4, done4;
  logic        tx434, busy434, done434;

  int unsigned vecs = 0;
  int unsigned miss = 0;
  int unsigned busy_cyc = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  last_byte;

  always #5 clk = ~clk;

  uart_xyz_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut4 (
    .clk50(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .z(z),
    .tx(tx4), .busy(busy4), .done(done4)
  );

  uart_xyz_tx dut434 (
    .clk50(clk), .rst_n(rst434), .start(start434), .x(x), .y(y), .z(z),
    .tx(tx434), .busy(busy434), .done(done434)
  );

  always @(negedge clk) begin
    if (busy4 === 1'b1) busy_cyc++;
    if (done4 === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receives one byte from the fast instance; returns at mid stop bit.
  task automatic get_byte(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int t = 0; t < 3000 && tx4 !== 1'b0; t++) @(negedge clk);
    if (tx4 !== 1'b0) return;
    repeat (2) @(negedge clk);
    if (tx4 !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx4;
    end
    repeat (4) @(negedge clk);
    ok = (tx4 === 1'b1);
  endtask

  // act_at: byte after which to act; act_poke=1 re-pulses start with new x,
  // act_poke=0 drops a held start.
  task automatic recv_frame(input string tag, input logic [31:0] fx, fy, fz,
                            input int act_at, input bit act_poke);
    logic [7:0]  exp [14];
    logic [95:0] w;
    logic [7:0]  sum;
    logic [7:0]  b;
    bit          ok;
    w      = {fx, fy, fz};
    sum    = '0;
    exp[0] = 8'hA5;
    for (int i = 0; i < 12; i++) begin
      exp[i+1] = w[95-8*i -: 8];
      sum      = sum + exp[i+1];
    end
    exp[13] = sum;
    for (int k = 0; k < 14; k++) begin
      get_byte(b, ok);
      check($sformatf("%s byte%0d", tag, k), ok ? {24'h0, b} : 32'h100, {24'h0, exp[k]});
      last_byte = b;
      if (k == act_at) begin
        if (act_poke) begin
          x = 32'hDEADBEEF;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end else begin
          start = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int unsigned b0, d0, n;
    logic [7:0]  b;
    bit          ok;
    logic        lvl;
    int unsigned runs [7];
    runs = '{434, 434, 434, 434, 868, 434, 434};

    repeat (3) @(negedge clk);
    check("rst tx", {31'h0, tx4}, 32'h1);
    check("rst busy", {31'h0, busy4}, 32'h0);
    check("rst done", {31'h0, done4}, 32'h0);
    check("rst tx434", {31'h0, tx434}, 32'h1);
    rst_n = 1'b1;
    rst434 = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame
    x = 32'h1; y = 32'h2; z = 32'h3;
    b0 = busy_cyc; d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latency tx", {31'h0, tx4}, 32'h0);
    check("latency busy", {31'h0, busy4}, 32'h1);
    recv_frame("basic", 32'h1, 32'h2, 32'h3, 99, 1'b0);
    repeat (10) @(negedge clk);
    check("basic cksum", {24'h0, last_byte}, 32'h06);
    check("basic busy cycles", busy_cyc - b0, 32'd560);
    check("basic done count", done_cnt - d0, 32'd1);

    // Checksum wrap
    x = '1; y = '1; z = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    recv_frame("wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 99, 1'b0);
    check("wrap cksum", {24'h0, last_byte}, 32'hF4);
    repeat (10) @(negedge clk);

    // Busy protection
    x = 32'h11223344; y = 32'h55667788; z = 32'h99AABBCC;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    recv_frame("busyprot", 32'h11223344, 32'h55667788, 32'h99AABBCC, 3, 1'b1);
    repeat (100) @(negedge clk);
    check("busyprot done count", done_cnt - d0, 32'd1);
    check("busyprot idle tx", {31'h0, tx4}, 32'h1);
    check("busyprot idle busy", {31'h0, busy4}, 32'h0);

    // Back-to-back with start held
    x = 32'hA1B2C3D4; y = 32'h0; z = 32'h80;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    recv_frame("b2b f1", 32'hA1B2C3D4, 32'h0, 32'h80, 99, 1'b0);
    n = 0;
    while (tx4 === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("b2b gap samples", n, 32'd3);
    recv_frame("b2b f2", 32'hA1B2C3D4, 32'h0, 32'h80, 0, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b done count", done_cnt - d0, 32'd2);
    check("b2b idle busy", {31'h0, busy4}, 32'h0);

    // Reset abort during byte 5
    x = 32'hCAFEF00D; y = 32'h12345678; z = 32'h0F0F0F0F;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      get_byte(b, ok);
      check($sformatf("abort pre byte%0d ok", k), {31'h0, ok}, 32'h1);
    end
    for (int t = 0; t < 50 && tx4 !== 1'b0; t++) @(negedge clk);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort tx", {31'h0, tx4}, 32'h1);
    check("abort busy", {31'h0, busy4}, 32'h0);
    check("abort done", {31'h0, done4}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("abort no done", done_cnt - d0, 32'd0);
    check("abort idle tx", {31'h0, tx4}, 32'h1);
    x = 32'h01020304; y = 32'hF0E0D0C0; z = 32'h7F800001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    recv_frame("after abort", 32'h01020304, 32'hF0E0D0C0, 32'h7F800001, 99, 1'b0);
    repeat (10) @(negedge clk);
    check("after abort done", done_cnt - d0, 32'd1);

    // Default bit timing: header A5 gives runs 0,1,0,1,00,1,0 of 434 cycles
    start434 = 1'b1;
    @(negedge clk);
    start434 = 1'b0;
    check("t434 start latency", {31'h0, tx434}, 32'h0);
    check("t434 busy", {31'h0, busy434}, 32'h1);
    for (int r = 0; r < 7; r++) begin
      n = 0;
      lvl = tx434;
      while (tx434 === lvl && n < 2000) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("t434 run%0d", r), n, runs[r]);
    end
    rst434 = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
